// File: rtl/ibuf_wr_ctrl.sv
// Write-side controller for the shared input buffer: turns 256-bit DMA beats into
// tagged RAM writes, optionally sign-extending int8 beats into two 16-bit-lane writes.
module ibuf_wr_ctrl #(
    parameter int MEM_DATA_WIDTH = 256,
    parameter int TAG_W          = 1,
    parameter int BUF_ADDR_W     = 13,
    parameter int LEN_W          = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        cfg_start,
    input  logic [BUF_ADDR_W-1:0]       cfg_base_addr,
    input  logic [LEN_W-1:0]            cfg_num_beats,
    input  logic [TAG_W-1:0]            cfg_tag,
    input  logic                        cfg_mode_8b,
    input  logic                        s_valid,
    output logic                        s_ready,
    input  logic [MEM_DATA_WIDTH-1:0]   s_data,
    input  logic                        s_last,
    output logic                        mem_write_req,
    output logic [TAG_W+BUF_ADDR_W-1:0] mem_write_addr,
    output logic [MEM_DATA_WIDTH-1:0]   mem_write_data,
    output logic                        mux_sel,
    output logic                        busy,
    output logic                        done,
    output logic                        err_len,
    output logic [1:0]                  dbg_state
);

    localparam int HALF = MEM_DATA_WIDTH / 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        EXPAND = 2'd2,
        FIN    = 2'd3
    } state_t;

    state_t                  state, state_nxt;
    logic [BUF_ADDR_W-1:0]   offset;
    logic [LEN_W-1:0]        beat_cnt;
    logic [LEN_W-1:0]        num_q;
    logic [TAG_W-1:0]        tag_q;
    logic                    mode_q;
    logic [HALF-1:0]         hi_q;
    logic                    accept;
    logic                    is_final;

    // Handshake: a beat transfers on any rising clk edge where s_valid and s_ready are both high.
    assign accept    = s_valid & s_ready;
    assign is_final  = (beat_cnt == num_q - LEN_W'(1));
    assign dbg_state = state;

    function automatic logic [MEM_DATA_WIDTH-1:0] sext_half(input logic [HALF-1:0] h);
        logic [MEM_DATA_WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < MEM_DATA_WIDTH / 16; i++) begin
            r[i*16 +: 16] = {{8{h[i*8+7]}}, h[i*8 +: 8]};
        end
        return r;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        s_ready   = 1'b0;
        case (state)
            IDLE: begin
                if (cfg_start) state_nxt = (cfg_num_beats == '0) ? FIN : RUN;
            end
            RUN: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    if (mode_q)        state_nxt = EXPAND;
                    else if (is_final) state_nxt = FIN;
                end
            end
            EXPAND:  state_nxt = is_final ? FIN : RUN;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            offset         <= '0;
            beat_cnt       <= '0;
            num_q          <= '0;
            tag_q          <= '0;
            mode_q         <= 1'b0;
            hi_q           <= '0;
            mem_write_req  <= 1'b0;
            mem_write_addr <= '0;
            mem_write_data <= '0;
            mux_sel        <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            err_len        <= 1'b0;
        end else begin
            mem_write_req <= 1'b0;
            done          <= 1'b0;
            case (state)
                IDLE: begin
                    if (cfg_start) begin
                        offset   <= cfg_base_addr;
                        beat_cnt <= '0;
                        num_q    <= cfg_num_beats;
                        tag_q    <= cfg_tag;
                        mode_q   <= cfg_mode_8b;
                        mux_sel  <= cfg_mode_8b;
                        err_len  <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                RUN: begin
                    if (accept) begin
                        mem_write_req  <= 1'b1;
                        mem_write_addr <= {tag_q, offset};
                        offset         <= offset + BUF_ADDR_W'(1);
                        if (s_last != is_final) err_len <= 1'b1;
                        if (mode_q) begin
                            mem_write_data <= sext_half(s_data[HALF-1:0]);
                            hi_q           <= s_data[MEM_DATA_WIDTH-1:HALF];
                        end else begin
                            mem_write_data <= s_data;
                            beat_cnt       <= beat_cnt + LEN_W'(1);
                        end
                    end
                end
                EXPAND: begin
                    // Offset wraps inside the tag region; the tag field is never touched.
                    mem_write_req  <= 1'b1;
                    mem_write_addr <= {tag_q, offset};
                    mem_write_data <= sext_half(hi_q);
                    offset         <= offset + BUF_ADDR_W'(1);
                    beat_cnt       <= beat_cnt + LEN_W'(1);
                end
                FIN: begin
                    done <= 1'b1;
                    busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ibuf_wr_ctrl.sv
// Bench for ibuf_wr_ctrl: randomized beats, reference model of expected RAM writes,
// scoreboard queue popped by an independent write monitor.
module tb_ibuf_wr_ctrl;

    localparam int W  = 256;
    localparam int AW = 13;
    localparam int EW = 1 + AW + W;

    logic          clk = 1'b0;
    logic          reset;
    logic          cfg_start;
    logic [AW-1:0] cfg_base_addr;
    logic [15:0]   cfg_num_beats;
    logic          cfg_tag;
    logic          cfg_mode_8b;
    logic          s_valid;
    logic          s_ready;
    logic [W-1:0]  s_data;
    logic          s_last;
    logic          mem_write_req;
    logic [AW:0]   mem_write_addr;
    logic [W-1:0]  mem_write_data;
    logic          mux_sel;
    logic          busy;
    logic          done;
    logic          err_len;
    logic [1:0]    dbg_state;

    ibuf_wr_ctrl dut (
        .clk(clk), .reset(reset), .cfg_start(cfg_start), .cfg_base_addr(cfg_base_addr),
        .cfg_num_beats(cfg_num_beats), .cfg_tag(cfg_tag), .cfg_mode_8b(cfg_mode_8b),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .mem_write_req(mem_write_req), .mem_write_addr(mem_write_addr),
        .mem_write_data(mem_write_data), .mux_sel(mux_sel), .busy(busy), .done(done),
        .err_len(err_len), .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // scoreboard state
    logic [EW-1:0] exp_q[$];
    int compared   = 0;
    int mismatched = 0;
    int last_wr_cyc = 0;
    int wr_total   = 0;
    int acc_total  = 0;
    int done_cnt   = 0;
    logic cur_mode8 = 1'b0;
    logic prev_acc8 = 1'b0;

    task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // reference model: signed int8 lane values rendered as 16-bit two's complement
    function automatic logic [W-1:0] expand_half(input logic [W-1:0] d, input int half);
        logic [W-1:0] r;
        int v;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            v = int'(d[(half*16+i)*8 +: 8]);
            if (v > 127) v = v - 256;
            r[i*16 +: 16] = 16'(v);
        end
        return r;
    endfunction

    function automatic logic [W-1:0] rand_beat();
        logic [W-1:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // monitor: pops expected writes and checks handshake-level properties
    always @(negedge clk) begin
        if (reset) begin
            if (mem_write_req) begin
                wr_total++;
                last_wr_cyc = cyc;
                if (exp_q.size() == 0) begin
                    check("unexpected_write", {1'b1, mem_write_addr, mem_write_data}, '0);
                end else begin
                    check("write", {mem_write_addr, mem_write_data}, exp_q.pop_front());
                end
                check("write_after_accept", EW'(wr_total <= acc_total * (cur_mode8 ? 2 : 1)), EW'(1));
            end
            if (prev_acc8) check("ready_low_expand", EW'(s_ready), EW'(0));
            prev_acc8 = s_valid && s_ready && cur_mode8;
            if (s_valid && s_ready) acc_total++;
            if (busy) check("mux_sel", EW'(mux_sel), EW'(cur_mode8));
            if (done) done_cnt++;
        end else begin
            prev_acc8 = 1'b0;
        end
    end

    task automatic check_idle_outputs(input string tag);
        check({tag, "_s_ready"}, EW'(s_ready), EW'(0));
        check({tag, "_wr_req"},  EW'(mem_write_req), EW'(0));
        check({tag, "_wr_addr"}, EW'(mem_write_addr), EW'(0));
        check({tag, "_wr_data"}, EW'(mem_write_data), EW'(0));
        check({tag, "_busy"},    EW'(busy), EW'(0));
        check({tag, "_done"},    EW'(done), EW'(0));
        check({tag, "_err_len"}, EW'(err_len), EW'(0));
        check({tag, "_mux_sel"}, EW'(mux_sel), EW'(0));
    endtask

    // driver: start pulse, beat stream, completion checks
    task automatic run_xfer(input logic [AW-1:0] base, input int n, input logic tag,
                            input logic m8, input int vpct, input int last_beat,
                            input logic use_first, input logic [W-1:0] first_beat);
        int c0;
        int k;
        int i;
        int wait_cyc;
        logic got_done;
        logic [W-1:0] d;
        logic [AW:0] a;
        @(posedge clk); #1;
        cur_mode8     = m8;
        wr_total      = 0;
        acc_total     = 0;
        cfg_base_addr = base;
        cfg_num_beats = 16'(n);
        cfg_tag       = tag;
        cfg_mode_8b   = m8;
        cfg_start     = 1'b1;
        c0 = cyc;
        @(posedge clk); #1;
        cfg_start = 1'b0;
        check("busy_rise", EW'(busy), EW'(1));
        check("err_cleared", EW'(err_len), EW'(0));
        k = 0;
        i = 0;
        wait_cyc = 0;
        while (i < n && wait_cyc < 400) begin
            d = (use_first && i == 0) ? first_beat : rand_beat();
            s_valid = ($urandom_range(99) < vpct);
            s_data  = d;
            s_last  = (i == last_beat);
            if (s_valid && s_ready) begin
                if (m8) begin
                    for (int h = 0; h < 2; h++) begin
                        a = {tag, AW'((int'(base) + k) % (1 << AW))};
                        exp_q.push_back({a, expand_half(d, h)});
                        k++;
                    end
                end else begin
                    a = {tag, AW'((int'(base) + k) % (1 << AW))};
                    exp_q.push_back({a, d});
                    k++;
                end
                i++;
            end
            @(posedge clk); #1;
            wait_cyc++;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        if (i < n) check("beat_timeout", EW'(i), EW'(n));
        got_done = 1'b0;
        for (int t = 0; t < 20 && !got_done; t++) begin
            @(negedge clk);
            if (done) begin
                got_done = 1'b1;
                if (n == 0) check("done_zero_len", EW'(cyc - c0), EW'(2));
                else        check("done_gap", EW'(cyc - last_wr_cyc), EW'(1));
                check("busy_fall", EW'(busy), EW'(0));
                check("err_len", EW'(err_len), EW'(last_beat >= 0 && last_beat != n - 1));
            end
        end
        if (!got_done) check("done_timeout", EW'(0), EW'(1));
        check("write_count", EW'(wr_total), EW'(n * (m8 ? 2 : 1)));
        check("queue_drained", EW'(exp_q.size()), EW'(0));
        exp_q.delete();
    endtask

    initial begin
        logic [W-1:0] fb;
        int dsnap;
        int n;
        reset = 1'b0; cfg_start = 1'b0; cfg_base_addr = '0; cfg_num_beats = '0;
        cfg_tag = 1'b0; cfg_mode_8b = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
        repeat (3) @(posedge clk);
        #1 check_idle_outputs("reset");
        reset = 1'b1;

        run_xfer(13'h0010, 4, 1'b1, 1'b0, 100, 3, 1'b0, '0);

        fb = rand_beat();
        fb[7:0]     = 8'h80;
        fb[135:128] = 8'h7F;
        run_xfer(13'h0040, 1, 1'b0, 1'b1, 100, 0, 1'b1, fb);

        run_xfer(13'h1FFE, 3, 1'b0, 1'b0, 100, 2, 1'b0, '0);
        run_xfer(13'h0100, 5, 1'b1, 1'b1, 50, 4, 1'b0, '0);
        run_xfer(13'h0200, 3, 1'b0, 1'b0, 100, 1, 1'b0, '0);
        run_xfer(13'h0300, 2, 1'b1, 1'b1, 70, 1, 1'b0, '0);
        run_xfer(13'h0400, 0, 1'b1, 1'b0, 100, -1, 1'b0, '0);

        // abandon a transfer with reset in the middle of RUN
        @(posedge clk); #1;
        cur_mode8 = 1'b0; wr_total = 0; acc_total = 0;
        cfg_base_addr = 13'h0500; cfg_num_beats = 16'd8; cfg_tag = 1'b1;
        cfg_mode_8b = 1'b0; cfg_start = 1'b1;
        @(posedge clk); #1;
        cfg_start = 1'b0;
        for (int j = 0; j < 2; j++) begin
            s_data = rand_beat(); s_valid = 1'b1; s_last = 1'b0;
            exp_q.push_back({1'b1, AW'(13'h0500 + j), s_data});
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        #2 reset = 1'b0;
        #1 check_idle_outputs("async_reset");
        exp_q.delete();
        dsnap = done_cnt;
        @(posedge clk); #1 reset = 1'b1;
        repeat (5) @(posedge clk);
        check("no_done_after_reset", EW'(done_cnt), EW'(dsnap));
        run_xfer(13'h0600, 3, 1'b0, 1'b1, 100, 2, 1'b0, '0);

        for (int r = 0; r < 4; r++) begin
            n = $urandom_range(6, 1);
            run_xfer(AW'($urandom_range(8191)), n, 1'($urandom_range(1)), 1'($urandom_range(1)),
                     $urandom_range(100, 30), n - 1, 1'b0, '0);
        end

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/ibuf_wr_ctrl.md
# ibuf_wr_ctrl

Write-side controller for the shared input buffer RAM. It takes 256-bit AXI read-data beats from the input-fetch DMA and converts them into tagged `mem_write_addr`/`mem_write_req`/`mem_write_data` writes for the ibuf port of the 8bit/16bit RAM mux. In 8-bit mode it sign-extends each beat into two 16-bit-lane writes. It also drives a stable precision select (`mux_sel`) for the mux.

## Interface

Parameters:
- `MEM_DATA_WIDTH`, 256, beat and RAM write width
- `TAG_W`, 1, buffer tag width (ping-pong)
- `BUF_ADDR_W`, 13, address width within one tag region
- `LEN_W`, 16, beat-count width

Ports:
- `clk`  in  1  clock
- `reset`  in  1  asynchronous, active-low reset
- `cfg_start`  in  1  one-cycle start pulse; sampled only in IDLE
- `cfg_base_addr`  in  BUF_ADDR_W  first write address within the tag region
- `cfg_num_beats`  in  LEN_W  number of input beats expected
- `cfg_tag`  in  TAG_W  target tag
- `cfg_mode_8b`  in  1  1 = int8 input expanded to 16-bit lanes; 0 = pass-through
- `s_valid`  in  1  input beat valid
- `s_ready`  out  1  input beat ready
- `s_data`  in  MEM_DATA_WIDTH  input beat
- `s_last`  in  1  DMA last-beat marker
- `mem_write_req`  out  1  RAM write strobe
- `mem_write_addr`  out  TAG_W+BUF_ADDR_W  `{tag, offset}`
- `mem_write_data`  out  MEM_DATA_WIDTH  RAM write data
- `mux_sel`  out  1  precision select to the RAM mux; equals the latched `cfg_mode_8b`
- `busy`  out  1  high from start acceptance until done
- `done`  out  1  one-cycle completion pulse
- `err_len`  out  1  sticky `s_last` mismatch flag

## Operation

- States: IDLE, RUN, EXPAND, FIN.
- **IDLE**
  - `s_ready`=0.
  - On `cfg_start`, latch base, count, tag and mode, and clear `err_len`.
  - If `cfg_num_beats`=0, go to FIN (no writes). Otherwise go to RUN.
- **RUN**
  - `s_ready`=1; an accept is `s_valid & s_ready`.
  - 16-bit mode: the accepted beat is written unchanged to the current offset, offset+1, beat count +1.
  - 8-bit mode: the write carries the low half, with lanes 0..15 each `{ {8{b[7]}}, b }` from `s_data` bytes 0..15. Offset+1, then go to EXPAND.
  - 16-bit mode: after the final beat, go to FIN.
- **EXPAND**
  - `s_ready`=0.
  - Write the held high half (bytes 16..31 sign-extended), offset+1, beat count +1.
  - Then go to RUN, or to FIN if that was the final beat.
- **FIN**: pulse `done`, then go to IDLE.
- Offset is BUF_ADDR_W bits and wraps modulo 2^BUF_ADDR_W. The tag field is never modified, so writes never leak into the other tag.
- `err_len` sets when `s_last`=1 on a non-final beat, or `s_last`=0 on the final beat. The transfer still terminates by count. `err_len` holds until the next accepted `cfg_start`.
- `cfg_start` while not in IDLE is ignored.
- `mux_sel` changes only on an accepted `cfg_start`, so it is stable for the whole transfer.
- The RAM mux port has no backpressure; writes are never stalled.

## Timing

- Reset values (async assert, sync release):
  - state=IDLE.
  - `s_ready`, `mem_write_req`, `busy`, `done`, `err_len`, `mux_sel`=0.
  - `mem_write_addr`, `mem_write_data`=0.
- All outputs are registered except `s_ready`, which is decoded from the state register.
- `busy` rises the cycle after `cfg_start` and falls together with the `done` pulse.
- Write latency is 1 cycle: the accept in cycle N gives `mem_write_req`=1 in N+1. In 8-bit mode the second-half write follows in N+2.
- Throughput:
  - 16-bit mode: 1 beat/cycle.
  - 8-bit mode: 1 beat per 2 cycles, with `s_ready` low every other cycle.
- `done` pulses the cycle after the last `mem_write_req`. For a zero-length transfer, `done` pulses 2 cycles after `cfg_start`.
- Reset mid-transfer abandons the transfer immediately: no further writes and no `done`.

## Test plan

- 16-bit mode, base=0x10, tag=1, 4 beats, `s_valid` continuous:
  - writes at 0x2010..0x2013 on consecutive cycles with unchanged data;
  - `done` 1 cycle after the 4th write;
  - `err_len`=0.
- 8-bit mode, 1 beat with byte0=0x80 and byte16=0x7F:
  - 2 writes, at base and base+1;
  - lane0 of the first write = 0xFF80, lane0 of the second write = 0x007F;
  - `s_ready` low during EXPAND;
  - `mux_sel`=1 throughout.
- Wrap: base=0x1FFE, tag=0, 16-bit mode, 3 beats:
  - addresses 0x1FFE, 0x1FFF, 0x0000;
  - the tag bit stays 0.
- `s_valid` toggling randomly, 8-bit mode, 5 beats:
  - exactly 10 writes in order;
  - no write without a preceding accept.
- `s_last` asserted on beat 2 of 3: `err_len`=1 and 3 writes still occur. A subsequent `cfg_start` clears `err_len`.
- `cfg_num_beats`=0:
  - no writes;
  - `done` 2 cycles after start.
- Reset asserted mid-RUN:
  - all outputs return to 0 asynchronously;
  - a new start after reset completes normally.
